camerametnios_frame_read_master: RTL

Avalon-MM read master that fetches a contiguous block of 32-bit words from an on-chip memory slave (single-port RAM, fixed 1-cycle read latency) and presents them on a ready/valid stream for the camera display path. Software or a frame sequencer loads a base address and word count and pulses start. Reads are pipelined, and an internal FIFO absorbs sink backpressure so that no returned data is ever dropped.

---
 rtl/camerametnios_frame_read_master.sv | 126 ++++++++++++
 1 files changed

// File: rtl/camerametnios_frame_read_master.sv
// Avalon-MM burst-less read master: fetches a contiguous word block from on-chip
// memory and streams it out through a first-word-fall-through FIFO.
module camerametnios_frame_read_master #(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [31:0]       src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic [1:0]        dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t             state;
    logic [1:0]         rst_pipe;
    logic               rst_n;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   words_left;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   fifo_count;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [31:0]        mem [FIFO_DEPTH];
    logic [CNT_W:0]     in_flight;
    logic               accept;
    logic               ret;
    logic               pop;

    // Reset asserts asynchronously but is released on a clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_pipe <= 2'b00;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    // Credit: words in flight plus words buffered never exceed the FIFO size,
    // so a returning word always finds a free slot.
    assign in_flight = {1'b0, outstanding} + {1'b0, fifo_count};
    assign avm_read  = (state == S_READ) && (words_left != '0) &&
                       (in_flight < (CNT_W+1)'(FIFO_DEPTH));
    assign accept    = avm_read && !avm_waitrequest;
    // Returns outside an active transfer are stale leftovers from an aborted one.
    assign ret       = avm_readdatavalid && (outstanding != '0) &&
                       ((state == S_READ) || (state == S_DRAIN));
    assign pop       = src_valid && src_ready;

    assign avm_address    = addr_q;
    assign avm_byteenable = 4'hF;
    assign busy           = (state == S_READ) || (state == S_DRAIN);
    assign done           = (state == S_DONE);
    assign src_valid      = (fifo_count != '0);
    assign src_data       = mem[rd_ptr];
    assign dbg_state      = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            words_left  <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q     <= {base_addr[ADDR_W-1:2], 2'b00};
                        words_left <= length;
                        state      <= (length != '0) ? S_READ : S_DONE;
                    end
                end
                S_READ: begin
                    if (accept) begin
                        addr_q     <= addr_q + ADDR_W'(4);
                        words_left <= words_left - LEN_W'(1);
                        if (words_left == LEN_W'(1)) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((outstanding == '0) && (fifo_count == '0)) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            case ({accept, ret})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase

            case ({ret, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (ret) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (ret) mem[wr_ptr] <= avm_readdata;
    end

endmodule
